// File: rtl/mmio_timer.sv
// Memory-mapped machine timer: 64-bit mtime/mtimecmp, msip, and ctrl behind a
// 256-byte window with one-cycle registered read data and a registered timer_irq.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
  parameter int          PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] w_data,
  input  logic [3:0]  we,
  output logic [31:0] r_data,
  output logic        hit,
  output logic        timer_irq,
  output logic        soft_irq
);
  localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic          in_win, wr, wr_lo, wr_hi;
  logic [5:0]    off;
  logic [63:0]   mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic          en_q, en_d, msip_q, msip_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [31:0]   rdata_d;
  logic          unused_ok;

  assign unused_ok = &{1'b0, addr[1:0]};

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) res[8*i +: 8] = wd[8*i +: 8];
    return res;
  endfunction

  assign in_win = (addr[31:8] == BASE_ADDR[31:8]);
  assign off    = addr[7:2];
  assign wr     = in_win && (we != 4'b0000);
  assign wr_lo  = wr && (off == 6'd0);
  assign wr_hi  = wr && (off == 6'd1);

  always_comb begin
    mtime_d    = mtime_q;
    pre_d      = pre_q;
    mtimecmp_d = mtimecmp_q;
    en_d       = en_q;
    msip_d     = msip_q;
    // A software write to mtime wins outright: no tick, and the prescaler restarts.
    if (wr_lo || wr_hi) begin
      mtime_d = {wr_hi ? merge(mtime_q[63:32], w_data, we) : mtime_q[63:32],
                 wr_lo ? merge(mtime_q[31:0],  w_data, we) : mtime_q[31:0]};
      pre_d   = '0;
    end else if (en_q) begin
      if (pre_q == PMAX) begin
        pre_d   = '0;
        mtime_d = mtime_q + 64'd1;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
    if (wr && off == 6'd2) mtimecmp_d[31:0]  = merge(mtimecmp_q[31:0],  w_data, we);
    if (wr && off == 6'd3) mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], w_data, we);
    if (wr && off == 6'd4 && we[0]) en_d   = w_data[0];
    if (wr && off == 6'd5 && we[0]) msip_d = w_data[0];
  end

  // Read mux sees pre-write state, so read+write in one cycle returns the old value.
  always_comb begin
    rdata_d = 32'd0;
    if (in_win) begin
      case (off)
        6'd0:    rdata_d = mtime_q[31:0];
        6'd1:    rdata_d = mtime_q[63:32];
        6'd2:    rdata_d = mtimecmp_q[31:0];
        6'd3:    rdata_d = mtimecmp_q[63:32];
        6'd4:    rdata_d = {30'd0, timer_irq, en_q};
        6'd5:    rdata_d = {31'd0, msip_q};
        default: rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime_q    <= 64'd0;
      mtimecmp_q <= '1;
      en_q       <= 1'b1;
      msip_q     <= 1'b0;
      pre_q      <= '0;
      r_data     <= 32'd0;
      hit        <= 1'b0;
      timer_irq  <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      en_q       <= en_d;
      msip_q     <= msip_d;
      pre_q      <= pre_d;
      r_data     <= rdata_d;
      hit        <= in_win;
      timer_irq  <= (mtime_q >= mtimecmp_q);
    end
  end

  assign soft_irq = msip_q;
endmodule

// File: tb/tb_mmio_timer.sv
// Bench for mmio_timer: two instances (PRESCALE 1 and 4) share stimulus; a reference
// model pushes expected outputs to a scoreboard, plus constant-checked tables/sequences.
module tb_mmio_timer;
  localparam logic [31:0] B = 32'hFFFF_FF00;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic [31:0]       addr = '0, w_data = '0;
  logic [3:0]        we = '0;
  logic [1:0][31:0]  r_o;
  logic [1:0]        hit_o, irq_o, sirq_o;

  mmio_timer #(.BASE_ADDR(B), .PRESCALE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .w_data(w_data), .we(we),
    .r_data(r_o[0]), .hit(hit_o[0]), .timer_irq(irq_o[0]), .soft_irq(sirq_o[0]));
  mmio_timer #(.BASE_ADDR(B), .PRESCALE(4)) u4 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .w_data(w_data), .we(we),
    .r_data(r_o[1]), .hit(hit_o[1]), .timer_irq(irq_o[1]), .soft_irq(sirq_o[1]));

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0][31:0] r;
    logic [1:0]       hit, irq, sirq;
  } exp_t;
  typedef struct {
    logic [31:0] a, wd;
    logic [3:0]  we;
    logic [31:0] er;
    logic        eh;
  } vec_t;

  exp_t        sbq[$];
  int          n_chk = 0, n_err = 0;
  logic [63:0] m_mt[2], m_cmp[2];
  logic        m_en[2], m_msip[2], m_irq[2];
  int          m_pre[2];
  int          m_p[2] = '{1, 4};
  logic [31:0] obs_r[2];
  logic        obs_hit[2], obs_irq[2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) res[8*i +: 8] = wd[8*i +: 8];
    return res;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mt[i] = 64'd0; m_cmp[i] = '1; m_en[i] = 1'b1; m_msip[i] = 1'b0;
      m_irq[i] = 1'b0; m_pre[i] = 0;
    end
  endtask

  task automatic model_step(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] w);
    exp_t e;
    logic inw;
    int   o;
    logic mt_wr;
    inw = (a[31:8] == B[31:8]);
    o   = int'(a[7:2]);
    for (int i = 0; i < 2; i++) begin
      e.hit[i] = inw;
      e.r[i]   = 32'd0;
      if (inw) begin
        if (o == 0)      e.r[i] = m_mt[i][31:0];
        else if (o == 1) e.r[i] = m_mt[i][63:32];
        else if (o == 2) e.r[i] = m_cmp[i][31:0];
        else if (o == 3) e.r[i] = m_cmp[i][63:32];
        else if (o == 4) e.r[i] = {30'd0, m_irq[i], m_en[i]};
        else if (o == 5) e.r[i] = {31'd0, m_msip[i]};
      end
      m_irq[i] = (m_mt[i] >= m_cmp[i]);
      e.irq[i] = m_irq[i];
      mt_wr = inw && (w != 0) && (o == 0 || o == 1);
      if (mt_wr) begin
        if (o == 0) m_mt[i][31:0]  = lanes(m_mt[i][31:0], wd, w);
        else        m_mt[i][63:32] = lanes(m_mt[i][63:32], wd, w);
        m_pre[i] = 0;
      end else if (m_en[i]) begin
        if (m_pre[i] == m_p[i] - 1) begin m_pre[i] = 0; m_mt[i] = m_mt[i] + 1; end
        else m_pre[i] = m_pre[i] + 1;
      end
      if (inw && w != 0) begin
        if (o == 2) m_cmp[i][31:0]  = lanes(m_cmp[i][31:0], wd, w);
        if (o == 3) m_cmp[i][63:32] = lanes(m_cmp[i][63:32], wd, w);
        if (o == 4 && w[0]) m_en[i]   = wd[0];
        if (o == 5 && w[0]) m_msip[i] = wd[0];
      end
      e.sirq[i] = m_msip[i];
    end
    sbq.push_back(e);
  endtask

  // One bus cycle: drive at negedge, push expectation, compare at the following negedge.
  task automatic cyc(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] w);
    exp_t e;
    addr = a; w_data = wd; we = w;
    model_step(a, wd, w);
    @(posedge clk);
    @(negedge clk);
    if (sbq.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
    end else begin
      e = sbq.pop_front();
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("sb_rdata%0d", i), r_o[i], e.r[i]);
        chk($sformatf("sb_hit%0d", i), hit_o[i], e.hit[i]);
        chk($sformatf("sb_tirq%0d", i), irq_o[i], e.irq[i]);
        chk($sformatf("sb_sirq%0d", i), sirq_o[i], e.sirq[i]);
        obs_r[i] = r_o[i]; obs_hit[i] = hit_o[i]; obs_irq[i] = irq_o[i];
      end
    end
    addr = 32'd0; w_data = 32'd0; we = 4'd0;
  endtask

  task automatic do_reset();
    addr = 32'd0; w_data = 32'd0; we = 4'd0;
    rst_n = 1'b0;
    sbq.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_rdata%0d", i), r_o[i], 0);
      chk($sformatf("rst_hit%0d", i), hit_o[i], 0);
      chk($sformatf("rst_tirq%0d", i), irq_o[i], 0);
      chk($sformatf("rst_sirq%0d", i), sirq_o[i], 0);
    end
    rst_n = 1'b1;
  endtask

  vec_t tbl[14];
  logic found;

  initial begin
    tbl[0]  = '{B + 32'h08, 32'h1234_5678, 4'hF, 32'hFFFF_FFFF, 1'b1};
    tbl[1]  = '{B + 32'h08, 32'h0,         4'h0, 32'h1234_5678, 1'b1};
    tbl[2]  = '{B + 32'h0C, 32'hAABB_CCDD, 4'h5, 32'hFFFF_FFFF, 1'b1};
    tbl[3]  = '{B + 32'h0C, 32'h0,         4'h0, 32'hFFBB_FFDD, 1'b1};
    tbl[4]  = '{B + 32'h14, 32'h0000_0001, 4'h1, 32'h0,         1'b1};
    tbl[5]  = '{B + 32'h14, 32'h0,         4'h0, 32'h1,         1'b1};
    tbl[6]  = '{B + 32'h14, 32'h0,         4'h2, 32'h1,         1'b1};
    tbl[7]  = '{B + 32'h14, 32'h0,         4'h0, 32'h1,         1'b1};
    tbl[8]  = '{32'h0000_1000, 32'h0,      4'h0, 32'h0,         1'b0};
    tbl[9]  = '{B + 32'h40, 32'h0,         4'h0, 32'h0,         1'b1};
    tbl[10] = '{B + 32'h40, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1};
    tbl[11] = '{B + 32'h42, 32'h0,         4'h0, 32'h0,         1'b1};
    tbl[12] = '{B + 32'h10, 32'h0,         4'h0, 32'h1,         1'b1};
    tbl[13] = '{B + 32'h16, 32'h0,         4'h0, 32'h1,         1'b1};

    // Count from reset, PRESCALE=1 instance reads 10 after ten idle cycles.
    do_reset();
    for (int k = 0; k < 10; k++) cyc(32'd0, 32'd0, 4'd0);
    cyc(B + 32'h00, 32'd0, 4'd0);
    chk("mtime_lo_after10", obs_r[0], 10);
    chk("hit_after10", obs_hit[0], 1);
    cyc(B + 32'h04, 32'd0, 4'd0);
    chk("mtime_hi_after10", obs_r[0], 0);
    chk("tirq_idle", obs_irq[0], 0);

    // Carry from low to high word.
    cyc(B + 32'h00, 32'hFFFF_FFFF, 4'hF);
    cyc(B + 32'h04, 32'h0, 4'hF);
    cyc(32'd0, 32'd0, 4'd0);
    cyc(32'd0, 32'd0, 4'd0);
    cyc(B + 32'h04, 32'd0, 4'd0);
    chk("carry_hi", obs_r[0], 1);

    // timer_irq rises one cycle after mtime reaches mtimecmp, drops after raising it.
    do_reset();
    cyc(B + 32'h08, 32'd20, 4'hF);
    cyc(B + 32'h0C, 32'd0, 4'hF);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      cyc(B + 32'h00, 32'd0, 4'd0);
      if (obs_r[0] == 19) chk("tirq_at19", obs_irq[0], 0);
      if (obs_r[0] == 20) begin chk("tirq_at20", obs_irq[0], 1); found = 1'b1; end
    end
    if (!found) chk("tirq_reach20_timeout", 0, 1);
    cyc(B + 32'h08, 32'd1000, 4'hF);
    chk("tirq_before_raise", obs_irq[0], 1);
    cyc(32'd0, 32'd0, 4'd0);
    chk("tirq_after_raise", obs_irq[0], 0);

    // Register table from a fresh reset.
    do_reset();
    foreach (tbl[k]) begin
      cyc(tbl[k].a, tbl[k].wd, tbl[k].we);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("tbl%0d_rdata%0d", k, i), obs_r[i], tbl[k].er);
        chk($sformatf("tbl%0d_hit%0d", k, i), obs_hit[i], tbl[k].eh);
      end
    end
    chk("tbl_soft_irq_held", sirq_o[0], 1);

    // PRESCALE=4: disable at cycle 8 freezes mtime at 2, re-enable ticks every 4.
    do_reset();
    for (int k = 0; k < 7; k++) cyc(32'd0, 32'd0, 4'd0);
    cyc(B + 32'h10, 32'd0, 4'hF);
    for (int k = 0; k < 20; k++) cyc(32'd0, 32'd0, 4'd0);
    cyc(B + 32'h00, 32'd0, 4'd0);
    chk("p4_frozen", obs_r[1], 2);
    chk("p1_frozen", obs_r[0], 8);
    cyc(B + 32'h10, 32'd1, 4'hF);
    for (int k = 0; k < 4; k++) cyc(32'd0, 32'd0, 4'd0);
    cyc(B + 32'h00, 32'd0, 4'd0);
    chk("p4_tick1", obs_r[1], 3);
    for (int k = 0; k < 3; k++) cyc(32'd0, 32'd0, 4'd0);
    cyc(B + 32'h00, 32'd0, 4'd0);
    chk("p4_tick2", obs_r[1], 4);

    // Asynchronous reset in the middle of activity.
    cyc(B + 32'h14, 32'd1, 4'h1);
    cyc(B + 32'h0C, 32'd0, 4'hF);
    cyc(B + 32'h08, 32'd0, 4'hF);
    cyc(B + 32'h00, 32'd0, 4'd0);
    cyc(B + 32'h10, 32'd0, 4'd0);
    chk("pre_rst_tirq", obs_irq[0], 1);
    chk("pre_rst_sirq", sirq_o[0], 1);
    addr = B; 
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("async_rdata%0d", i), r_o[i], 0);
      chk($sformatf("async_hit%0d", i), hit_o[i], 0);
      chk($sformatf("async_tirq%0d", i), irq_o[i], 0);
      chk($sformatf("async_sirq%0d", i), sirq_o[i], 0);
    end
    @(negedge clk);
    do_reset();
    cyc(B + 32'h08, 32'd0, 4'd0);
    chk("cmp_lo_after_rst", obs_r[0], 32'hFFFF_FFFF);
    cyc(B + 32'h0C, 32'd0, 4'd0);
    chk("cmp_hi_after_rst", obs_r[1], 32'hFFFF_FFFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mmio_timer.md
Name: mmio_timer

Overview:
- Memory-mapped machine-timer responder on the core's data-access port: answers the core's addr / w_data / byte-we requests with one-cycle registered read data, matching the synchronous-RAM timing the memory/writeback stage expects.
- Holds a 64-bit mtime counter, a 64-bit mtimecmp and a software-interrupt bit, and drives timer_irq / soft_irq toward the CSR trap logic.
- Sits beside the data RAM; the top level muxes r_data between RAM and this block using hit.

Parameters:
- BASE_ADDR, 32'hFFFF_FF00, base of the 256-byte register window (aligned to 256).
- PRESCALE, 1, clk cycles per mtime increment; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- addr  input  32  byte address from the core's data port (same cycle as we).
- w_data  input  32  write data, already lane-aligned by the core's memory-access controller.
- we  input  4  byte-lane write enables; bit i covers w_data[8i+7:8i].
- r_data  output  32  registered read data for the address sampled at the previous edge.
- hit  output  1  registered; 1 when the previous-cycle address fell inside the window.
- timer_irq  output  1  registered; 1 while mtime >= mtimecmp (unsigned, 64-bit).
- soft_irq  output  1  equals msip bit.

Behaviour:
- Reset (async, rst_n=0): mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, enable=1, msip=0, prescaler=0, r_data=0, hit=0, timer_irq=0, soft_irq=0. Reset asserted mid-operation clears everything immediately; no pending write survives.
- Decode: in window when addr[31:8]==BASE_ADDR[31:8]. Offset = addr[7:2]; addr[1:0] ignored.
- Register map (byte offset):
  - 0x00 mtime[31:0], R/W.
  - 0x04 mtime[63:32], R/W.
  - 0x08 mtimecmp[31:0], R/W.
  - 0x0C mtimecmp[63:32], R/W.
  - 0x10 ctrl: bit0 enable (R/W); bit1 timer_irq (RO); other bits read 0.
  - 0x14 msip: bit0 R/W; other bits read 0.
  - 0x18-0xFF read 0, writes ignored, hit still 1.
- Read timing: every edge, r_data <= value at the decoded offset and hit <= in_window; out of window gives r_data=0, hit=0. Latency is exactly 1 cycle and no enable is needed. A read plus write to the same register in one cycle returns the old (pre-write) value.
- Writes: occur at the edge where we!=0 and in_window. Only the lanes with we[i]=1 change.
- Prescaler: counts 0..PRESCALE-1 while enable=1. At PRESCALE-1 it wraps to 0 and mtime increments by 1 as a full 64-bit add, so the carry propagates from the low word to the high word. 64'hFFFF_FFFF_FFFF_FFFF wraps to 0. With enable=0 both the prescaler and mtime hold.
- Write to any mtime byte: mtime <= old mtime with the written bytes replaced. There is no increment that cycle and the prescaler clears to 0. A write to one half leaves the other half unchanged, including any carry it would have received.
- timer_irq: timer_irq <= (mtime >= mtimecmp) using the current register values. It follows a register change by 1 cycle and deasserts 1 cycle after mtimecmp is raised above mtime. It is level-sensitive and not sticky.
- soft_irq: combinational copy of the msip register.
- Estimated RTL size: ~150-200 lines.

Test Plan:
- Reset then idle 10 cycles, PRESCALE=1: read 0x00 gives r_data=10 one cycle later, hit=1; read 0x04 gives 0; timer_irq=0.
- Write 0x00=FFFF_FFFF and 0x04=0 (we=4'hF), then idle 2 cycles: read 0x04 gives 1; the low word is 1 at the time of the read.
- Write mtimecmp_lo=20, mtimecmp_hi=0 after reset: timer_irq rises exactly 1 cycle after mtime reaches 20. Then write mtimecmp_lo=1000: timer_irq drops 1 cycle after the write.
- Byte write 0x14 with we=4'b0001, w_data=32'h0000_0001: soft_irq=1. Read 0x14 gives 1. Write with we=4'b0010 and data 0: soft_irq stays 1.
- PRESCALE=4, write ctrl=0 at cycle 8, wait 20 cycles: mtime frozen at 2. Write ctrl=1: mtime increments every 4 cycles.
- Read at addr 32'h0000_1000: hit=0, r_data=0. Read at BASE+0x40: hit=1, r_data=0. Assert rst_n=0 mid-count: all outputs are 0 asynchronously and mtimecmp reads all-ones after release.
